// File: rtl/dmem_ctrl.sv
// Data-memory controller: user RAM, system RAM, memory-mapped I/O and fault reporting behind a req/done handshake.
// Optional I/O acknowledge timeout enabled by defining DMEM_IO_TIMEOUT_EN.
module dmem_ctrl #(
    parameter int          USER_WORDS = 4096,
    parameter logic [31:0] SYS_BASE   = 32'h0000_4000,
    parameter int          SYS_WORDS  = 2048,
    parameter logic [31:0] IO_BASE    = 32'h1000_0000,
    parameter int          IO_TIMEOUT = 16
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iReq,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iAddress,
    input  logic [3:0]  iByteEnable,
    input  logic [31:0] iWriteData,
    output logic        oReady,
    output logic        oDone,
    output logic        oFault,
    output logic [31:0] oMemData,
    output logic        oIOReq,
    output logic        oIOWrite,
    output logic [31:0] oIOAddr,
    output logic [3:0]  oIOByteEn,
    output logic [31:0] oIOWData,
    input  logic        iIOAck,
    input  logic [31:0] iIOData
);
    localparam int UW = $clog2(USER_WORDS);
    localparam int SW = $clog2(SYS_WORDS);

    if (IO_TIMEOUT < 2) begin : g_param_check
        $error("IO_TIMEOUT must be at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_IO, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        fault_q, fault_d;
    logic        io_req_q, io_req_d;
    logic        io_write_q, io_write_d;
    logic [31:0] io_addr_q, io_addr_d;
    logic [3:0]  io_be_q, io_be_d;
    logic [31:0] io_wdata_q, io_wdata_d;
    logic        ram_pend_q, ram_pend_d;
    logic        ram_sel_q, ram_sel_d;
`ifdef DMEM_IO_TIMEOUT_EN
    localparam int CW = $clog2(IO_TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    logic [31:0] user_mem [USER_WORDS];
    logic [31:0] sys_mem  [SYS_WORDS];
    logic [31:0] user_rd_q, sys_rd_q, ram_rd;

    logic [31:0] word_addr, sys_off;
    logic        is_io, is_user, is_sys, accept, valid_op;
    logic        wr_user, wr_sys, rd_user, rd_sys;

    assign word_addr = {2'b00, iAddress[31:2]};
    assign sys_off   = word_addr - SYS_BASE;
    assign is_io     = iAddress >= IO_BASE;
    assign is_user   = word_addr < 32'(USER_WORDS);
    assign is_sys    = (word_addr >= SYS_BASE) && (sys_off < 32'(SYS_WORDS));
    assign oReady    = (state_q == S_IDLE) || (state_q == S_RESP);
    assign accept    = iReq && oReady;
    assign valid_op  = iMemRead ^ iMemWrite;

    // Region decode priority: I/O, then user, then system.
    assign wr_user = accept && valid_op && iMemWrite && !is_io && is_user;
    assign rd_user = accept && valid_op && iMemRead  && !is_io && is_user;
    assign wr_sys  = accept && valid_op && iMemWrite && !is_io && !is_user && is_sys;
    assign rd_sys  = accept && valid_op && iMemRead  && !is_io && !is_user && is_sys;

    always_ff @(posedge iCLK) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_user && iByteEnable[b])
                user_mem[word_addr[UW-1:0]][8*b +: 8] <= iWriteData[8*b +: 8];
        end
        if (rd_user)
            user_rd_q <= user_mem[word_addr[UW-1:0]];
    end

    always_ff @(posedge iCLK) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_sys && iByteEnable[b])
                sys_mem[sys_off[SW-1:0]][8*b +: 8] <= iWriteData[8*b +: 8];
        end
        if (rd_sys)
            sys_rd_q <= sys_mem[sys_off[SW-1:0]];
    end

    // RAM read data is shown directly during its completion cycle and captured for holding afterwards.
    assign ram_rd   = ram_sel_q ? sys_rd_q : user_rd_q;
    assign oMemData = (state_q == S_RESP && ram_pend_q) ? ram_rd : mem_data_q;

    always_comb begin
        state_d    = state_q;
        mem_data_d = mem_data_q;
        fault_d    = 1'b0;
        io_req_d   = io_req_q;
        io_write_d = io_write_q;
        io_addr_d  = io_addr_q;
        io_be_d    = io_be_q;
        io_wdata_d = io_wdata_q;
        ram_pend_d = 1'b0;
        ram_sel_d  = ram_sel_q;
`ifdef DMEM_IO_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        if (state_q == S_RESP && ram_pend_q)
            mem_data_d = ram_rd;

        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    if (!valid_op) begin
                        state_d = S_RESP;
                        fault_d = 1'b1;
                    end else if (is_io) begin
                        state_d    = S_IO;
                        io_req_d   = 1'b1;
                        io_write_d = iMemWrite;
                        io_addr_d  = iAddress;
                        io_be_d    = iByteEnable;
                        io_wdata_d = iWriteData;
`ifdef DMEM_IO_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end else if (is_user || is_sys) begin
                        state_d    = S_RESP;
                        ram_pend_d = iMemRead;
                        ram_sel_d  = !is_user;
                    end else begin
                        state_d    = S_RESP;
                        fault_d    = 1'b1;
                        mem_data_d = 32'h0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IO: begin
                if (iIOAck) begin
                    state_d  = S_RESP;
                    io_req_d = 1'b0;
                    if (!io_write_q)
                        mem_data_d = iIOData;
                end
`ifdef DMEM_IO_TIMEOUT_EN
                // An ack on the last allowed cycle is taken above, before the timeout.
                else if (cnt_q == CW'(IO_TIMEOUT - 1)) begin
                    state_d    = S_RESP;
                    io_req_d   = 1'b0;
                    fault_d    = 1'b1;
                    mem_data_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= S_IDLE;
            mem_data_q <= 32'h0;
            fault_q    <= 1'b0;
            io_req_q   <= 1'b0;
            io_write_q <= 1'b0;
            io_addr_q  <= 32'h0;
            io_be_q    <= 4'h0;
            io_wdata_q <= 32'h0;
            ram_pend_q <= 1'b0;
            ram_sel_q  <= 1'b0;
`ifdef DMEM_IO_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mem_data_q <= mem_data_d;
            fault_q    <= fault_d;
            io_req_q   <= io_req_d;
            io_write_q <= io_write_d;
            io_addr_q  <= io_addr_d;
            io_be_q    <= io_be_d;
            io_wdata_q <= io_wdata_d;
            ram_pend_q <= ram_pend_d;
            ram_sel_q  <= ram_sel_d;
`ifdef DMEM_IO_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign oDone     = (state_q == S_RESP);
    assign oFault    = fault_q;
    assign oIOReq    = io_req_q;
    assign oIOWrite  = io_write_q;
    assign oIOAddr   = io_addr_q;
    assign oIOByteEn = io_be_q;
    assign oIOWData  = io_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl: RAM regions, faults, I/O handshake, back-to-back and reset.
module tb_dmem_ctrl;
    logic        iCLK, iRST_n, iReq, iMemRead, iMemWrite;
    logic [31:0] iAddress, iWriteData, iIOData;
    logic [3:0]  iByteEnable;
    logic        iIOAck;
    logic        oReady, oDone, oFault, oIOReq, oIOWrite;
    logic [31:0] oMemData, oIOAddr, oIOWData;
    logic [3:0]  oIOByteEn;

    int pass_cnt = 0;
    int total_cnt = 0;

    dmem_ctrl #(
        .USER_WORDS(4096), .SYS_BASE(32'h0000_4000), .SYS_WORDS(2048),
        .IO_BASE(32'h1000_0000), .IO_TIMEOUT(16)
    ) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iReq(iReq), .iMemRead(iMemRead),
        .iMemWrite(iMemWrite), .iAddress(iAddress), .iByteEnable(iByteEnable),
        .iWriteData(iWriteData), .oReady(oReady), .oDone(oDone), .oFault(oFault),
        .oMemData(oMemData), .oIOReq(oIOReq), .oIOWrite(oIOWrite), .oIOAddr(oIOAddr),
        .oIOByteEn(oIOByteEn), .oIOWData(oIOWData), .iIOAck(iIOAck), .iIOData(iIOData)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Called at a falling edge: presents a request for the next rising edge.
    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] data);
        iReq = 1'b1; iMemRead = rd; iMemWrite = wr;
        iAddress = addr; iByteEnable = be; iWriteData = data;
        $display("req rd=%0b wr=%0b addr=%h be=%b data=%h", rd, wr, addr, be, data);
    endtask

    // One isolated request; returns at the falling edge of the completion cycle.
    task automatic single(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] data);
        drive(rd, wr, addr, be, data);
        @(negedge iCLK);
        iReq = 1'b0;
    endtask

    task automatic test_reset;
        total_cnt++; if (oReady !== 1'b1) $display("FAIL rst_ready: got %b want 1", oReady); else pass_cnt++;
        total_cnt++; if (oDone !== 1'b0) $display("FAIL rst_done: got %b want 0", oDone); else pass_cnt++;
        total_cnt++; if (oFault !== 1'b0) $display("FAIL rst_fault: got %b want 0", oFault); else pass_cnt++;
        total_cnt++; if (oIOReq !== 1'b0 || oIOWrite !== 1'b0) $display("FAIL rst_ioreq: got %b%b want 00", oIOReq, oIOWrite); else pass_cnt++;
        total_cnt++; if (oMemData !== 32'h0) $display("FAIL rst_memdata: got %h want 0", oMemData); else pass_cnt++;
        total_cnt++; if (oIOAddr !== 32'h0 || oIOWData !== 32'h0 || oIOByteEn !== 4'h0)
            $display("FAIL rst_iobus: got %h %h %b want zeros", oIOAddr, oIOWData, oIOByteEn); else pass_cnt++;
    endtask

    task automatic test_user_rw;
        single(1'b0, 1'b1, 32'h10, 4'b1111, 32'hAABBCCDD);
        total_cnt++; if (oDone !== 1'b1 || oFault !== 1'b0) $display("FAIL wr_full_done: got %b/%b want 1/0", oDone, oFault); else pass_cnt++;
        total_cnt++; if (oMemData !== 32'h0) $display("FAIL wr_keeps_memdata: got %h want 0", oMemData); else pass_cnt++;
        single(1'b0, 1'b1, 32'h10, 4'b0001, 32'h00000011);
        total_cnt++; if (oDone !== 1'b1) $display("FAIL wr_byte_done: got %b want 1", oDone); else pass_cnt++;
        single(1'b1, 1'b0, 32'h10, 4'b0000, 32'h0);
        total_cnt++; if (oDone !== 1'b1 || oFault !== 1'b0) $display("FAIL rd_user_done: got %b/%b want 1/0", oDone, oFault); else pass_cnt++;
        total_cnt++; if (oMemData !== 32'hAABBCC11) $display("FAIL rd_user_data: got %h want aabbcc11", oMemData); else pass_cnt++;
        @(negedge iCLK);
        total_cnt++; if (oDone !== 1'b0) $display("FAIL done_pulse: got %b want 0", oDone); else pass_cnt++;
        total_cnt++; if (oMemData !== 32'hAABBCC11) $display("FAIL memdata_hold: got %h want aabbcc11", oMemData); else pass_cnt++;
    endtask

    task automatic test_regions;
        single(1'b0, 1'b1, 32'h0001_0000, 4'b1111, 32'h12345678);
        total_cnt++; if (oDone !== 1'b1 || oFault !== 1'b0) $display("FAIL wr_sys_done: got %b/%b want 1/0", oDone, oFault); else pass_cnt++;
        single(1'b1, 1'b0, 32'h0001_0000, 4'b0000, 32'h0);
        total_cnt++; if (oMemData !== 32'h12345678) $display("FAIL rd_sys_data: got %h want 12345678", oMemData); else pass_cnt++;
        single(1'b1, 1'b0, 32'h0000_4000, 4'b0000, 32'h0);
        total_cnt++; if (oDone !== 1'b1 || oFault !== 1'b1) $display("FAIL unmapped_fault: got %b/%b want 1/1", oDone, oFault); else pass_cnt++;
        total_cnt++; if (oMemData !== 32'h0) $display("FAIL unmapped_data: got %h want 0", oMemData); else pass_cnt++;
        single(1'b0, 1'b1, 32'h0000_3FFC, 4'b1111, 32'hA5A50001);
        single(1'b1, 1'b0, 32'h0000_3FFC, 4'b0000, 32'h0);
        total_cnt++; if (oMemData !== 32'hA5A50001 || oFault !== 1'b0) $display("FAIL user_last_word: got %h/%b want a5a50001/0", oMemData, oFault); else pass_cnt++;
        single(1'b0, 1'b1, 32'h0001_1FFC, 4'b1111, 32'h5A5A0002);
        single(1'b1, 1'b0, 32'h0001_1FFC, 4'b0000, 32'h0);
        total_cnt++; if (oMemData !== 32'h5A5A0002 || oFault !== 1'b0) $display("FAIL sys_last_word: got %h/%b want 5a5a0002/0", oMemData, oFault); else pass_cnt++;
        single(1'b1, 1'b0, 32'h0001_2000, 4'b0000, 32'h0);
        total_cnt++; if (oFault !== 1'b1 || oMemData !== 32'h0) $display("FAIL sys_end_unmapped: got %b/%h want 1/0", oFault, oMemData); else pass_cnt++;
        single(1'b1, 1'b1, 32'h10, 4'b1111, 32'hFFFFFFFF);
        total_cnt++; if (oDone !== 1'b1 || oFault !== 1'b1) $display("FAIL both_ops_fault: got %b/%b want 1/1", oDone, oFault); else pass_cnt++;
        single(1'b0, 1'b0, 32'h10, 4'b1111, 32'hFFFFFFFF);
        total_cnt++; if (oDone !== 1'b1 || oFault !== 1'b1) $display("FAIL no_op_fault: got %b/%b want 1/1", oDone, oFault); else pass_cnt++;
        single(1'b1, 1'b0, 32'h10, 4'b0000, 32'h0);
        total_cnt++; if (oMemData !== 32'hAABBCC11) $display("FAIL invalid_no_write: got %h want aabbcc11", oMemData); else pass_cnt++;
    endtask

    task automatic test_io_read;
        int hi = 0;
        int guard = 0;
        single(1'b1, 1'b0, 32'h1000_0004, 4'b1111, 32'h0);
        total_cnt++; if (oIOReq !== 1'b1 || oIOWrite !== 1'b0 || oIOAddr !== 32'h1000_0004 || oDone !== 1'b0)
            $display("FAIL io_rd_start: got req=%b wr=%b addr=%h done=%b want 1 0 10000004 0", oIOReq, oIOWrite, oIOAddr, oDone); else pass_cnt++;
        while (oIOReq === 1'b1 && guard < 50) begin
            hi++;
            if (hi == 3) begin iIOAck = 1'b1; iIOData = 32'hCAFEF00D; end
            @(negedge iCLK);
            iIOAck = 1'b0;
            guard++;
        end
        total_cnt++; if (hi != 3) $display("FAIL io_rd_req_cycles: got %0d want 3", hi); else pass_cnt++;
        total_cnt++; if (oDone !== 1'b1 || oFault !== 1'b0) $display("FAIL io_rd_done: got %b/%b want 1/0", oDone, oFault); else pass_cnt++;
        total_cnt++; if (oMemData !== 32'hCAFEF00D) $display("FAIL io_rd_data: got %h want cafef00d", oMemData); else pass_cnt++;
        @(negedge iCLK);
        iIOAck = 1'b1; iIOData = 32'h0BADBEEF;
        @(negedge iCLK);
        @(negedge iCLK);
        iIOAck = 1'b0;
        total_cnt++; if (oDone !== 1'b0 || oIOReq !== 1'b0 || oMemData !== 32'hCAFEF00D)
            $display("FAIL stray_ack: got done=%b req=%b data=%h want 0 0 cafef00d", oDone, oIOReq, oMemData); else pass_cnt++;
    endtask

    task automatic test_io_write_fast;
        single(1'b0, 1'b1, 32'h1000_0008, 4'b0110, 32'h11223344);
        total_cnt++; if (oIOReq !== 1'b1 || oIOWrite !== 1'b1 || oIOByteEn !== 4'b0110 || oIOWData !== 32'h11223344)
            $display("FAIL io_wr_bus: got req=%b wr=%b be=%b d=%h want 1 1 0110 11223344", oIOReq, oIOWrite, oIOByteEn, oIOWData); else pass_cnt++;
        iIOAck = 1'b1; iIOData = 32'h77777777;
        @(negedge iCLK);
        iIOAck = 1'b0;
        total_cnt++; if (oDone !== 1'b1 || oIOReq !== 1'b0 || oFault !== 1'b0)
            $display("FAIL io_wr_2cycle: got done=%b req=%b fault=%b want 1 0 0", oDone, oIOReq, oFault); else pass_cnt++;
        total_cnt++; if (oMemData !== 32'hCAFEF00D) $display("FAIL io_wr_keeps_data: got %h want cafef00d", oMemData); else pass_cnt++;
        @(negedge iCLK);
    endtask

`ifdef DMEM_IO_TIMEOUT_EN
    task automatic test_io_timeout;
        int hi = 0;
        int guard = 0;
        single(1'b0, 1'b1, 32'h1000_0020, 4'b1111, 32'h55AA55AA);
        while (oIOReq === 1'b1 && guard < 100) begin
            hi++;
            @(negedge iCLK);
            guard++;
        end
        total_cnt++; if (hi != 16) $display("FAIL timeout_cycles: got %0d want 16", hi); else pass_cnt++;
        total_cnt++; if (oDone !== 1'b1 || oFault !== 1'b1 || oMemData !== 32'h0)
            $display("FAIL timeout_fault: got done=%b fault=%b data=%h want 1 1 0", oDone, oFault, oMemData); else pass_cnt++;
        @(negedge iCLK);
        hi = 0; guard = 0;
        single(1'b1, 1'b0, 32'h1000_0024, 4'b1111, 32'h0);
        while (oIOReq === 1'b1 && guard < 100) begin
            hi++;
            if (hi == 16) begin iIOAck = 1'b1; iIOData = 32'h600DF00D; end
            @(negedge iCLK);
            iIOAck = 1'b0;
            guard++;
        end
        total_cnt++; if (hi != 16 || oDone !== 1'b1 || oFault !== 1'b0 || oMemData !== 32'h600DF00D)
            $display("FAIL ack_last_cycle: got n=%0d done=%b fault=%b data=%h want 16 1 0 600df00d", hi, oDone, oFault, oMemData); else pass_cnt++;
        @(negedge iCLK);
    endtask
`else
    task automatic test_io_long_wait;
        int hi = 0;
        int guard = 0;
        single(1'b1, 1'b0, 32'h1000_0024, 4'b1111, 32'h0);
        while (oIOReq === 1'b1 && guard < 100) begin
            hi++;
            if (hi == 30) begin iIOAck = 1'b1; iIOData = 32'h600DF00D; end
            @(negedge iCLK);
            iIOAck = 1'b0;
            guard++;
        end
        total_cnt++; if (hi != 30 || oDone !== 1'b1 || oFault !== 1'b0 || oMemData !== 32'h600DF00D)
            $display("FAIL io_long_wait: got n=%0d done=%b fault=%b data=%h want 30 1 0 600df00d", hi, oDone, oFault, oMemData); else pass_cnt++;
        @(negedge iCLK);
    endtask
`endif

    task automatic test_back_to_back;
        logic [31:0] exp [4];
        for (int k = 0; k < 4; k++) exp[k] = 32'h1000_0000 + 32'(k * 3 + 1);
        drive(1'b0, 1'b1, 32'h40, 4'b1111, exp[0]);
        for (int k = 1; k < 4; k++) begin
            @(negedge iCLK);
            total_cnt++; if (oDone !== 1'b1) $display("FAIL b2b_wr_done%0d: got %b want 1", k - 1, oDone); else pass_cnt++;
            drive(1'b0, 1'b1, 32'h40 + 32'(4 * k), 4'b1111, exp[k]);
        end
        @(negedge iCLK);
        drive(1'b1, 1'b0, 32'h40, 4'b0000, 32'h0);
        for (int k = 1; k < 4; k++) begin
            @(negedge iCLK);
            total_cnt++; if (oDone !== 1'b1 || oMemData !== exp[k - 1])
                $display("FAIL b2b_rd%0d: got done=%b data=%h want 1 %h", k - 1, oDone, oMemData, exp[k - 1]); else pass_cnt++;
            drive(1'b1, 1'b0, 32'h40 + 32'(4 * k), 4'b0000, 32'h0);
        end
        @(negedge iCLK);
        iReq = 1'b0;
        total_cnt++; if (oDone !== 1'b1 || oMemData !== exp[3])
            $display("FAIL b2b_rd3: got done=%b data=%h want 1 %h", oDone, oMemData, exp[3]); else pass_cnt++;
        @(negedge iCLK);
        drive(1'b0, 1'b1, 32'h50, 4'b1111, 32'hDEADBEEF);
        @(negedge iCLK);
        drive(1'b1, 1'b0, 32'h50, 4'b0000, 32'h0);
        @(negedge iCLK);
        iReq = 1'b0;
        total_cnt++; if (oDone !== 1'b1 || oMemData !== 32'hDEADBEEF)
            $display("FAIL wr_then_rd: got done=%b data=%h want 1 deadbeef", oDone, oMemData); else pass_cnt++;
        @(negedge iCLK);
    endtask

    task automatic test_reset_mid_io;
        single(1'b1, 1'b0, 32'h1000_0010, 4'b1111, 32'h0);
        total_cnt++; if (oIOReq !== 1'b1) $display("FAIL rst_io_pre: got %b want 1", oIOReq); else pass_cnt++;
        #2 iRST_n = 1'b0;
        #1;
        total_cnt++; if (oIOReq !== 1'b0 || oReady !== 1'b1 || oDone !== 1'b0)
            $display("FAIL rst_io_async: got req=%b ready=%b done=%b want 0 1 0", oIOReq, oReady, oDone); else pass_cnt++;
        @(negedge iCLK);
        iRST_n = 1'b1;
        @(negedge iCLK);
        total_cnt++; if (oReady !== 1'b1 || oIOReq !== 1'b0) $display("FAIL rst_io_after: got ready=%b req=%b want 1 0", oReady, oIOReq); else pass_cnt++;
        single(1'b1, 1'b0, 32'h10, 4'b0000, 32'h0);
        total_cnt++; if (oDone !== 1'b1 || oMemData !== 32'hAABBCC11)
            $display("FAIL rst_ram_kept: got done=%b data=%h want 1 aabbcc11", oDone, oMemData); else pass_cnt++;
        single(1'b1, 1'b0, 32'h0001_0000, 4'b0000, 32'h0);
        total_cnt++; if (oMemData !== 32'h12345678) $display("FAIL rst_sys_kept: got %h want 12345678", oMemData); else pass_cnt++;
    endtask

    initial begin
        iRST_n = 1'b0; iReq = 1'b0; iMemRead = 1'b0; iMemWrite = 1'b0;
        iAddress = 32'h0; iByteEnable = 4'h0; iWriteData = 32'h0;
        iIOAck = 1'b0; iIOData = 32'h0;
        repeat (2) @(negedge iCLK);
        test_reset;
        iRST_n = 1'b1;
        @(negedge iCLK);
        test_user_rw;
        test_regions;
        test_io_read;
        test_io_write_fast;
`ifdef DMEM_IO_TIMEOUT_EN
        test_io_timeout;
`else
        test_io_long_wait;
`endif
        test_back_to_back;
        test_reset_mid_io;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller for the pipelined MIPS datapath, successor to the fixed user/system data memory. It decodes byte addresses into user RAM, system RAM, memory-mapped I/O and unmapped space, all with configurable sizes and bases. Accesses use a request/done handshake, so I/O devices can insert wait states. Unmapped or timed-out accesses are reported as faults instead of silently returning zero.

## Interface
- USER_WORDS, 4096: user RAM depth in 32-bit words, at word address 0.
- SYS_BASE, 32'h00004000: system RAM base, as a word address.
- SYS_WORDS, 2048: system RAM depth in words.
- IO_BASE, 32'h10000000: byte address at and above which accesses go to I/O.
- IO_TIMEOUT, 16: maximum wait for an I/O acknowledge, in cycles; minimum 2.
- iCLK  in  1  clock; all state updates on the rising edge.
- iRST_n  in  1  asynchronous, active-low reset.
- iReq  in  1  access request; sampled only while oReady=1.
- iMemRead  in  1  read access.
- iMemWrite  in  1  write access.
- iAddress  in  32  byte address; bits [1:0] ignored, word address = iAddress[31:2].
- iByteEnable  in  4  write lane enables; bit n enables bits [8n+7:8n].
- iWriteData  in  32  write data.
- oReady  out  1  controller can accept a request this cycle.
- oDone  out  1  one-cycle completion pulse.
- oFault  out  1  completion was a fault; valid only with oDone.
- oMemData  out  32  read data; updated at completion and held until the next completion.
- oIOReq  out  1  I/O request; held until acknowledged or timed out.
- oIOWrite  out  1  I/O access is a write.
- oIOAddr  out  32  I/O byte address.
- oIOByteEn  out  4  I/O lane enables.
- oIOWData  out  32  I/O write data.
- iIOAck  in  1  I/O acknowledge.
- iIOData  in  32  I/O read data; valid when iIOAck=1.

## Operation
- States:
  - IDLE: ready for a new request.
  - IO: I/O access in progress.
  - RESP: completion cycle.
- oReady = (state==IDLE) or (state==RESP).
- Acceptance: iReq=1 and oReady=1 at a rising edge. Address, data, enables and the decode result are latched at that edge.
- Region decode priority:
  - I/O if iAddress >= IO_BASE.
  - Otherwise user if word < USER_WORDS.
  - Otherwise system if SYS_BASE <= word < SYS_BASE+SYS_WORDS.
  - Otherwise unmapped.
- Access validity:
  - Exactly one of iMemRead/iMemWrite must be set.
  - Both or neither set is a fault: no write occurs and state goes to RESP.
- User/system write: enabled lanes are written at the acceptance edge, then RESP with oFault=0. oMemData is unchanged.
- User/system read: synchronous RAM read at the acceptance edge, then RESP; oMemData is loaded with the full word. Byte enables are ignored for reads.
- Unmapped access: no write, then RESP with oFault=1; oMemData is loaded with 0.
- I/O access:
  - Go to IO and drive oIOReq=1 with latched oIOWrite/oIOAddr/oIOByteEn/oIOWData, stable until exit.
  - On iIOAck=1: drop oIOReq, load oMemData with iIOData (reads only), then RESP with oFault=0.
- RESP: oDone=1. A request accepted in RESP is processed exactly as from IDLE (back-to-back). With no request, next state is IDLE.
- Write-then-read to the same word on consecutive accepted requests returns the new data; no forwarding logic is needed because the write completes before the read.
- Reset mid-operation: state returns to IDLE immediately; oIOReq drops asynchronously. A pending I/O transfer is abandoned. RAM contents are not cleared.

## Timing
- Reset values:
  - state = IDLE, oReady = 1.
  - oDone, oFault, oIOReq, oIOWrite = 0.
  - oMemData, oIOAddr, oIOWData = 0; oIOByteEn = 0.
- RAM read/write latency: request accepted at edge N, oDone=1 in cycle N+1. Sustained throughput is one access per cycle.
- I/O latency: oIOReq rises the cycle after acceptance. An ack sampled at edge M gives oDone in cycle M+1. An ack in the first oIOReq cycle yields a 2-cycle total.
- iIOAck while oIOReq=0 is ignored.

## Configuration
- DMEM_IO_TIMEOUT_EN defined:
  - A counter is cleared on entry to IO and increments each cycle oIOReq=1.
  - If no ack arrives within IO_TIMEOUT cycles: drop oIOReq, go to RESP with oFault=1, load oMemData with 0.
  - An ack on the final allowed cycle wins over timeout.
- DMEM_IO_TIMEOUT_EN undefined: no counter; IO waits indefinitely for iIOAck.

## Test plan
- Write 32'hAABBCCDD to byte address 0x10 with enable 4'b1111, then write 32'h00000011 with enable 4'b0001, then read 0x10 -> oMemData=32'hAABBCC11, oFault=0, each oDone one cycle after acceptance.
- Write 32'h12345678 to 0x10000 (word 0x4000, system region), then read it -> 32'h12345678; read 0x4000 (word 0x1000, unmapped) -> oDone with oFault=1, oMemData=0.
- I/O read at 0x10000004, iIOAck asserted on the 3rd oIOReq cycle with iIOData=32'hCAFEF00D -> oIOReq high for exactly 3 cycles, oDone next cycle, oMemData=32'hCAFEF00D.
- DMEM_IO_TIMEOUT_EN with IO_TIMEOUT=16, I/O write never acked -> oIOReq high for 16 cycles, then oDone with oFault=1.
- iReq held high for 4 back-to-back user reads -> oDone high 4 consecutive cycles, each with the correct data.
- iRST_n pulled low while oIOReq=1 -> oIOReq=0 immediately, oReady=1 after release, next RAM read returns the pre-reset contents.
